vec3_accum: RTL and testbench

VEC3_ACCUM -- requirements
Module: vec3_accum

---
 rtl/vec3_accum.sv | 152 +++++++++++++++
 tb/tb_vec3_accum.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vec3_accum.sv
// vec3_accum: averages 2^SPP_LOG2 fp32 vec3 samples, divides by exponent shift.
// Build option: define ACCUM_CLAMP_EN to clamp each sample to [0,1] before the add.
module vec3_accum #(
  parameter int    SPP_LOG2 = 4,
  parameter string USE_DSP  = "MED"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [95:0] in_color,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [95:0] out_color,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADD, SCALE, OUT} state_t;

  localparam logic [7:0] SH = 8'(SPP_LOG2);
  localparam logic [SPP_LOG2:0] FULL = (SPP_LOG2+1)'(1 << SPP_LOG2);

  // Single-cycle fp32 add, round-to-nearest-even, denormals kept.
  function automatic logic [31:0] fadd(input logic [31:0] x,
                                       input logic [31:0] y);
    logic [31:0] a, b;
    logic [9:0]  ea, eb, e, d;
    logic [27:0] ma, mb, s, mask;
    logic        st, up;
    logic [24:0] m;
    if (x[30:0] >= y[30:0]) begin
      a = x; b = y;
    end else begin
      a = y; b = x;
    end
    if (a[30:23] == 8'hff) begin
      if (b[30:23] == 8'hff && a[31] != b[31]) return 32'h7fc00000;
      return a;
    end
    ea = (a[30:23] == 8'h00) ? 10'd1 : {2'b00, a[30:23]};
    eb = (b[30:23] == 8'h00) ? 10'd1 : {2'b00, b[30:23]};
    ma = {1'b0, a[30:23] != 8'h00, a[22:0], 3'b000};
    mb = {1'b0, b[30:23] != 8'h00, b[22:0], 3'b000};
    d = ea - eb;
    if (d > 10'd27) d = 10'd27;
    mask = ~(28'hfffffff << d);
    st = |(mb & mask);
    mb = (mb >> d) | {27'b0, st};
    s = (a[31] == b[31]) ? ma + mb : ma - mb;
    e = ea;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    for (int i = 0; i < 27; i++) begin
      if (!s[26] && e > 10'd1) begin
        s = s << 1;
        e = e - 10'd1;
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m = {1'b0, s[26:3]} + {24'b0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {a[31], 8'hff, 23'b0};
    if (m == 25'd0) return 32'h0;
    return {a[31], m[23] ? e[7:0] : 8'h00, m[22:0]};
  endfunction

  // Divide by 2^SPP_LOG2; values that would go subnormal flush to signed zero.
  function automatic logic [31:0] scale(input logic [31:0] v);
    if (v[30:23] == 8'hff) return v;
    if (v[30:23] <= SH) return {v[31], 31'b0};
    return {v[31], v[30:23] - SH, v[22:0]};
  endfunction

`ifdef ACCUM_CLAMP_EN
  function automatic logic [31:0] clamp(input logic [31:0] v);
    if (v[31] || (v[30:23] == 8'hff && v[22:0] != 23'b0)) return 32'h0;
    if (v > 32'h3f800000) return 32'h3f800000;
    return v;
  endfunction
`endif

  state_t            state, nxt;
  logic [95:0]       acc, sum, smp;
  logic              add_vld;
  logic [SPP_LOG2:0] cnt, cnt_inc;
  logic              take, done;

  assign in_rdy  = (state == IDLE) && !rst;
  assign out_vld = (state == OUT);
  assign take    = in_vld && in_rdy;
  assign done    = out_vld && out_rdy;
  assign busy    = (state != IDLE) || (cnt != '0);
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    smp = '0;
    for (int c = 0; c < 3; c++) begin
`ifdef ACCUM_CLAMP_EN
      smp[32*c +: 32] = clamp(in_color[32*c +: 32]);
`else
      smp[32*c +: 32] = in_color[32*c +: 32];
`endif
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (take) nxt = ADD;
      ADD:     if (add_vld) nxt = (cnt_inc == FULL) ? SCALE : IDLE;
      SCALE:   nxt = OUT;
      OUT:     if (out_rdy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      sum       <= '0;
      cnt       <= '0;
      add_vld   <= 1'b0;
      out_color <= '0;
    end else begin
      state   <= nxt;
      add_vld <= take;
      if (take) begin
        for (int c = 0; c < 3; c++)
          sum[32*c +: 32] <= fadd(acc[32*c +: 32], smp[32*c +: 32]);
      end
      if (state == ADD && add_vld) begin
        acc <= sum;
        cnt <= cnt_inc;
      end
      if (state == SCALE) begin
        for (int c = 0; c < 3; c++)
          out_color[32*c +: 32] <= scale(acc[32*c +: 32]);
      end
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vec3_accum.sv
// tb_vec3_accum: directed vectors for vec3_accum at SPP_LOG2 = 2, 4, 0 and 1.
module tb_vec3_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_vld[4], in_rdy[4], out_vld[4], out_rdy[4], busy[4];
  logic [95:0] in_color[4], out_color[4];

  vec3_accum #(.SPP_LOG2(2)) u0 (
    .clk(clk), .rst(rst), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
    .in_color(in_color[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]),
    .out_color(out_color[0]), .busy(busy[0]));
  vec3_accum #(.SPP_LOG2(4)) u1 (
    .clk(clk), .rst(rst), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
    .in_color(in_color[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]),
    .out_color(out_color[1]), .busy(busy[1]));
  vec3_accum #(.SPP_LOG2(0)) u2 (
    .clk(clk), .rst(rst), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]),
    .in_color(in_color[2]), .out_vld(out_vld[2]), .out_rdy(out_rdy[2]),
    .out_color(out_color[2]), .busy(busy[2]));
  vec3_accum #(.SPP_LOG2(1)) u3 (
    .clk(clk), .rst(rst), .in_vld(in_vld[3]), .in_rdy(in_rdy[3]),
    .in_color(in_color[3]), .out_vld(out_vld[3]), .out_rdy(out_rdy[3]),
    .out_color(out_color[3]), .busy(busy[3]));

  typedef struct packed {
    logic [3:0][95:0] s;
    logic [95:0]      e;
  } vec_t;

  vec_t tbl[4];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [95:0] v3(input logic [31:0] x,
                                     input logic [31:0] y,
                                     input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [95:0] v);
    int n = 0;
    while (!in_rdy[d] && n < 20) begin
      tick();
      n++;
    end
    if (!in_rdy[d]) chk("in_rdy_wait", 128'(in_rdy[d]), 128'd1);
    in_vld[d]   = 1'b1;
    in_color[d] = v;
    tick();
    in_vld[d]   = 1'b0;
    in_color[d] = {3{32'hbadbad00}};
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_vld[d] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [95:0] v123;
    v123 = v3(32'h3f800000, 32'h40000000, 32'h40400000);

    tbl[0].s = {4{v123}};
    tbl[0].e = v123;
    tbl[1].s = {v3(32'h40600000, 32'h0, 32'h3f800000),
                v3(32'h40200000, 32'h0, 32'h3f800000),
                v3(32'h3fc00000, 32'h0, 32'h3f800000),
                v3(32'h3f000000, 32'h0, 32'h3f800000)};
    tbl[1].e = v3(32'h40000000, 32'h0, 32'h3f800000);
    tbl[2].s = {v3(32'hc0800000, 32'h41000000, 32'hbf800000),
                v3(32'h40800000, 32'h41000000, 32'hbf800000),
                v3(32'hc0000000, 32'h41000000, 32'hbf800000),
                v3(32'h40000000, 32'h41000000, 32'hbf800000)};
    tbl[2].e = v3(32'h0, 32'h41000000, 32'hbf800000);
    tbl[3].s = {v3(32'h3f800000, 32'h3e800000, 32'h41100000),
                v3(32'h3f800000, 32'h3e800000, 32'h40e00000),
                v3(32'h3f800000, 32'h3e800000, 32'h40a00000),
                v3(32'h7f800000, 32'h3e800000, 32'h40400000)};
    tbl[3].e = v3(32'h7f800000, 32'h3e800000, 32'h40c00000);

    for (int d = 0; d < 4; d++) begin
      in_vld[d]   = 1'b0;
      in_color[d] = '0;
      out_rdy[d]  = 1'b1;
    end
    rst = 1'b1;
    tick();
    tick();
    chk("reset_state", {in_rdy[0], busy[0], out_vld[0], out_color[0]}, '0);
    rst = 1'b0;
    tick();
    chk("in_rdy_after_reset", {busy[0], in_rdy[0]}, 2'b01);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) send(0, tbl[i].s[k]);
      wait_out(0, lat);
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'd2);
      chk($sformatf("tbl%0d_color", i), out_color[0], tbl[i].e);
      tick();
      chk($sformatf("tbl%0d_idle", i), {out_vld[0], busy[0], in_rdy[0]},
          3'b001);
    end

    out_rdy[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, v123);
    wait_out(0, lat);
    chk("stall_color", out_color[0], v123);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall_hold%0d", c), {out_vld[0], in_rdy[0], out_color[0]},
          {1'b1, 1'b0, v123});
    end
    out_rdy[0] = 1'b1;
    tick();
    chk("stall_release", {out_vld[0], busy[0], in_rdy[0]}, 3'b001);

    send(0, v3(32'h3f800000, 32'h3f800000, 32'h3f800000));
    send(0, v3(32'h3f800000, 32'h3f800000, 32'h3f800000));
    rst = 1'b1;
    tick();
    chk("midpixel_reset", {busy[0], out_vld[0], in_rdy[0]}, 3'b000);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(0, {3{32'h40800000}});
    wait_out(0, lat);
    chk("after_reset_color", out_color[0], {3{32'h40800000}});
    tick();

    for (int k = 0; k < 16; k++) send(1, v3(32'h00800000, 32'h40000000, 32'h0));
    wait_out(1, lat);
    chk("spp4_minnormal", out_color[1], v3(32'h00800000, 32'h40000000, 32'h0));
    tick();
    send(1, v3(32'h00800000, 32'h0, 32'h0));
    for (int k = 0; k < 15; k++) send(1, '0);
    wait_out(1, lat);
    chk("spp4_flush_zero", out_color[1], '0);
    tick();

    send(2, v3(32'h3fc00000, 32'hc0000000, 32'h7fc00000));
    wait_out(2, lat);
    chk("spp0_latency", 128'(lat), 128'd2);
    chk("spp0_color", out_color[2], v3(32'h3fc00000, 32'hc0000000, 32'h7fc00000));
    tick();

    send(3, v3(32'hc0400000, 32'h0, 32'h0));
    send(3, v3(32'h40a00000, 32'h0, 32'h0));
    wait_out(3, lat);
`ifdef ACCUM_CLAMP_EN
    chk("spp1_clamp", out_color[3], v3(32'h3f000000, 32'h0, 32'h0));
`else
    chk("spp1_signed", out_color[3], v3(32'h3f800000, 32'h0, 32'h0));
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
